sd_access_arbiter: RTL
======================

Name: sd_access_arbiter

Overview:
Two-port round-robin arbiter and transaction sequencer in front of the SD-card SPI command controller. Port 0 serves the boot loader (reads) and port 1 serves the host write path. The block latches one requester's address, direction and write data, and drives the controller's read/write enables. It waits for the transaction-complete pulse, or a timeout, and returns read data plus a one-cycle acknowledge to the granted requester.

Parameters:
ADDR_W, 32, SD block address width
DATA_W, 32, read/write data word width
TIMEOUT_CYCLES, 65535, cycles in WAIT before a transaction is aborted with error (minimum 2)

Ports:
control_clk_i  in  1  system clock
control_rst_i  in  1  asynchronous, active-high reset
req0_i  in  1  port 0 request (level)
we0_i  in  1  port 0 direction, 1=write, 0=read
addr0_i  in  ADDR_W  port 0 SD address
wdata0_i  in  DATA_W  port 0 write data
req1_i, we1_i, addr1_i, wdata1_i  in  1/1/ADDR_W/DATA_W  port 1, same meaning
gnt0_o, gnt1_o  out  1  grant, one-hot, held from ISSUE through RESP
ack0_o, ack1_o  out  1  one-cycle completion pulse to the granted port
rdata_o  out  DATA_W  read data, valid in the ack cycle, holds until next read completes
err_o  out  1  timeout flag, valid only in the ack cycle
sd_ready_i  in  1  controller initialisation complete (past CMD58)
sd_done_i  in  1  controller transaction-complete pulse
sd_rdata_i  in  DATA_W  controller read data (mem_data)
sd_address_o  out  ADDR_W  latched address to controller
sd_dataw_o  out  DATA_W  latched write data to controller
sd_re_o, sd_we_o  out  1  read/write enables to controller, mutually exclusive

Behaviour:
- Reset (async): state=IDLE; all outputs 0; timer=0; last_gnt=1, so port 0 wins the first contest. Reset mid-transaction aborts with no ack; the requester must re-request.
- FSM states: IDLE, ISSUE, WAIT, RESP, all registered. Outputs are registered.
- IDLE:
  - If sd_ready_i=0: no grant, stay.
  - Else if any req: winner = the only requester, or on contention the port != last_gnt.
  - Latch winner's addr/we/wdata into sd_address_o/sd_dataw_o/dir; go to ISSUE.
- ISSUE (1 cycle):
  - Assert winner's gnt.
  - Set sd_re_o=~dir or sd_we_o=dir; clear timer; go to WAIT.
- WAIT:
  - Hold gnt, enable, address and data stable.
  - Timer increments each cycle.
  - sd_done_i=1: if read, capture sd_rdata_i into rdata_o; err=0; go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1: err=1, rdata_o unchanged; go to RESP.
  - Done and timeout in the same cycle: done wins, err=0.
- RESP (1 cycle):
  - Pulse ack of the granted port; err_o=err.
  - Deassert sd_re_o/sd_we_o.
  - last_gnt = granted port; next cycle gnt=0, state=IDLE.
- Latency: req sampled in IDLE at edge N; gnt and enable at N+1; ack at the cycle after the done is sampled. Minimum request-to-ack is 4 cycles.
- Requesters change inputs only when not granted. Input changes while granted are ignored because the values are latched.
- A requester dropping req mid-transaction is ignored; the transaction completes and ack still pulses.
- A req still high in the cycle after ack is treated as a new request. Round-robin then favours the other port if it is requesting.
- sd_done_i outside WAIT is ignored.
- sd_ready_i falling during a transaction does not abort it; it only blocks new grants.
- we and re are never asserted together; a grant is never given to both ports.

Test Plan:
- Single read port 0: addr0=0x00000200, we0=0, sd_done pulse 10 cycles after sd_re_o with sd_rdata=0xDEADBEEF -> gnt0 one cycle after req, sd_address_o=0x200, sd_re_o=1, sd_we_o=0, ack0 single pulse, rdata_o=0xDEADBEEF, err_o=0.
- Single write port 1: addr1=0x400, wdata1=0x12345678 -> sd_we_o=1, sd_dataw_o=0x12345678, ack1 after done, rdata_o unchanged.
- Contention: req0 and req1 asserted together and held for 3 transactions -> grant order 0,1,0; never both gnt; each ack matches its grant.
- Timeout: TIMEOUT_CYCLES=16, no sd_done -> enable held exactly 16 WAIT cycles, ack with err_o=1, enable deasserts, next request served normally.
- Gating and abort: sd_ready_i=0 with req0=1 -> no grant for 20 cycles, grant 1 cycle after sd_ready_i rises; async reset in WAIT -> all outputs 0 immediately, no ack, IDLE.
- Edge case: sd_done_i and timeout expiry in the same cycle -> err_o=0 and rdata captured. sd_done_i pulsed in IDLE -> no ack.

Source files
------------

// File: rtl/sd_access_arbiter.sv
// Two-port round-robin arbiter and transaction sequencer in front of the SD SPI command controller.
// The block latches one request, drives the controller enables, and returns an ack on done or on timeout.
module sd_access_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              control_clk_i,
  input  logic              control_rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  input  logic              sd_ready_i,
  input  logic              sd_done_i,
  input  logic [DATA_W-1:0] sd_rdata_i,
  output logic [ADDR_W-1:0] sd_address_o,
  output logic [DATA_W-1:0] sd_dataw_o,
  output logic              sd_re_o,
  output logic              sd_we_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               last_gnt_q, last_gnt_d;
  logic               sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               gnt0_d, gnt1_d, ack0_d, ack1_d, err_d, re_d, we_d;
  logic [DATA_W-1:0]  rdata_d, dataw_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               win_p1;

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    gnt0_d     = gnt0_o;
    gnt1_d     = gnt1_o;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;
    re_d       = sd_re_o;
    we_d       = sd_we_o;
    rdata_d    = rdata_o;
    dataw_d    = sd_dataw_o;
    addr_d     = sd_address_o;
    // Port 1 wins when alone, or on contention when port 0 was served last.
    win_p1     = req1_i && (!req0_i || !last_gnt_q);

    case (state_q)
      S_IDLE: begin
        if (sd_ready_i && (req0_i || req1_i)) begin
          sel_d   = win_p1;
          dir_d   = win_p1 ? we1_i    : we0_i;
          addr_d  = win_p1 ? addr1_i  : addr0_i;
          dataw_d = win_p1 ? wdata1_i : wdata0_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt0_d  = !sel_q;
        gnt1_d  = sel_q;
        re_d    = !dir_q;
        we_d    = dir_q;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (sd_done_i || (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
          if (sd_done_i && !dir_q) begin
            rdata_d = sd_rdata_i;
          end
          err_d   = !sd_done_i;
          ack0_d  = !sel_q;
          ack1_d  = sel_q;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        last_gnt_d = sel_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge control_clk_i or posedge control_rst_i) begin
    if (control_rst_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      last_gnt_q   <= 1'b1;
      sel_q        <= 1'b0;
      dir_q        <= 1'b0;
      gnt0_o       <= 1'b0;
      gnt1_o       <= 1'b0;
      ack0_o       <= 1'b0;
      ack1_o       <= 1'b0;
      err_o        <= 1'b0;
      sd_re_o      <= 1'b0;
      sd_we_o      <= 1'b0;
      rdata_o      <= '0;
      sd_dataw_o   <= '0;
      sd_address_o <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_gnt_q   <= last_gnt_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      gnt0_o       <= gnt0_d;
      gnt1_o       <= gnt1_d;
      ack0_o       <= ack0_d;
      ack1_o       <= ack1_d;
      err_o        <= err_d;
      sd_re_o      <= re_d;
      sd_we_o      <= we_d;
      rdata_o      <= rdata_d;
      sd_dataw_o   <= dataw_d;
      sd_address_o <= addr_d;
    end
  end

endmodule
